// File: rtl/data_sync_pkg.sv
// Shared constants, channel-index width helper and index typedef for the
// multi-channel data synchroniser.
package data_sync_pkg;

  localparam int DS_NUM_CH  = 4;
  localparam int DS_D_WIDTH = 8;
  localparam int DS_STAGES  = 2;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [ch_w(DS_NUM_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser into the CLK domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified bus synchroniser merged into one valid/ready
// stream by a round-robin arbiter. Optional bus_ack return handshake: DATA_SYNC_ACK_EN.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int NUM_CH  = DS_NUM_CH,
  parameter int D_WIDTH = DS_D_WIDTH,
  parameter int STAGES  = DS_STAGES,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_CH*D_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]         bus_enable,
  output logic [NUM_CH-1:0]         enable_pulse,
  output logic [D_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]           out_ch,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH-1:0]         overflow,
`ifdef DATA_SYNC_ACK_EN
  output logic [NUM_CH-1:0]         bus_ack,
`endif
  input  logic                      ovf_clr
);

  logic [NUM_CH-1:0]  sync;
  logic [NUM_CH-1:0]  prev;
  logic [NUM_CH-1:0]  rise;
  logic [NUM_CH-1:0]  hold_full;
  logic [NUM_CH-1:0]  full_next;
  logic [NUM_CH-1:0]  ovf_next;
  logic [NUM_CH-1:0]  capture;
  logic [NUM_CH-1:0]  granted;
  logic [D_WIDTH-1:0] hold_data [NUM_CH];
  logic [CH_W-1:0]    ptr;
  logic [CH_W-1:0]    grant_idx;
  logic               grant_any;
  logic               load;
  logic               take;

  assign load = !out_valid || out_ready;
  assign take = load && grant_any;

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int cand;
      cand = (int'(ptr) + k) % NUM_CH;
      if (!grant_any && hold_full[cand]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(cand);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      bit_sync #(.STAGES(STAGES)) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (bus_enable[gi]),
        .q   (sync[gi])
      );

      assign rise[gi]    = sync[gi] & ~prev[gi];
      assign granted[gi] = take && (grant_idx == CH_W'(gi));
      // A grant in the same cycle frees the slot, so the new word still fits.
      assign capture[gi] = rise[gi] && (!hold_full[gi] || granted[gi]);
      assign full_next[gi] = capture[gi] ? 1'b1 :
                             granted[gi] ? 1'b0 : hold_full[gi];
      assign ovf_next[gi]  = (rise[gi] && !capture[gi]) ? 1'b1 :
                             ovf_clr ? 1'b0 : overflow[gi];
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev         <= '0;
      enable_pulse <= '0;
      hold_full    <= '0;
      overflow     <= '0;
      for (int c = 0; c < NUM_CH; c++) hold_data[c] <= '0;
    end else begin
      prev         <= sync;
      enable_pulse <= rise;
      hold_full    <= full_next;
      overflow     <= ovf_next;
      for (int c = 0; c < NUM_CH; c++) begin
        if (capture[c]) hold_data[c] <= unsync_bus[c*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      ptr       <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      if (grant_any) begin
        out_data  <= hold_data[grant_idx];
        out_ch    <= grant_idx;
        out_valid <= 1'b1;
        ptr       <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DATA_SYNC_ACK_EN
  // Set on grant takes priority over the clear from a low synchronised enable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bus_ack <= '0;
    else     bus_ack <= (bus_ack & sync) | granted;
  end
`endif

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench for data_sync_mc: scoreboard queue filled by stimulus,
// drained by a monitor on every accepted output word.
module tb_data_sync_mc;

  localparam int NC = 4;
  localparam int DW = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NC*DW-1:0] unsync_bus = '0;
  logic [NC-1:0]   bus_enable = '0;
  logic [NC-1:0]   enable_pulse;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NC-1:0]   overflow;
  logic            ovf_clr = 1'b0;
`ifdef DATA_SYNC_ACK_EN
  logic [NC-1:0]   bus_ack;
`endif

  int total = 0;
  int bad   = 0;
  logic [9:0] sb [$];

  data_sync_mc #(.NUM_CH(NC), .D_WIDTH(DW), .STAGES(2)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .unsync_bus   (unsync_bus),
    .bus_enable   (bus_enable),
    .enable_pulse (enable_pulse),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
`ifdef DATA_SYNC_ACK_EN
    .bus_ack      (bus_ack),
`endif
    .ovf_clr      (ovf_clr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] d, input logic en);
    unsync_bus[c*DW +: DW] = d;
    bus_enable[c] = en;
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge CLK) begin
    logic [9:0] e;
    if (!RST && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got ch=%0d data=%0h expected none", out_ch, out_data);
      end else begin
        e = sb.pop_front();
        $display("xfer ch=%0d data=%0h", out_ch, out_data);
        if ({out_ch, out_data} !== e) begin
          bad++;
          $display("FAIL word: got ch=%0d data=%0h expected ch=%0d data=%0h",
                   out_ch, out_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_pulse", enable_pulse, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    RST = 1'b0;

    // Single capture on ch0
    out_ready = 1'b1;
    sb.push_back({2'd0, 8'hA5});
    set_ch(0, 8'hA5, 1'b1);
    tick(); tick();
    check("t1_pulse_e2", enable_pulse, 4'b0000);
    tick();
    check("t1_pulse_e3", enable_pulse, 4'b0001);
    check("t1_valid_e3", out_valid, 0);
    tick();
    check("t1_pulse_e4", enable_pulse, 4'b0000);
    check("t1_valid_e4", out_valid, 1);
    check("t1_data_e4", out_data, 8'hA5);
`ifdef DATA_SYNC_ACK_EN
    check("t1_ack", bus_ack, 4'b0001);
`endif
    tick();
    check("t1_valid_e5", out_valid, 0);
    set_ch(0, 8'h00, 1'b0);
    repeat (4) tick();

    // Round robin from a fresh pointer
    RST = 1'b1; tick(); RST = 1'b0;
    for (int c = 0; c < NC; c++) begin
      sb.push_back({2'(c), 8'(8'h10 + c)});
      set_ch(c, 8'(8'h10 + c), 1'b1);
    end
    repeat (3) tick();
    for (int c = 0; c < NC; c++) begin
      tick();
      check("rr4_valid", out_valid, 1);
      check("rr4_ch", out_ch, c);
    end
    tick();
    check("rr4_idle", out_valid, 0);
    bus_enable = '0;
    repeat (4) tick();

    sb.push_back({2'd0, 8'h20});
    sb.push_back({2'd2, 8'h22});
    set_ch(0, 8'h20, 1'b1);
    set_ch(2, 8'h22, 1'b1);
    repeat (4) tick();
    check("rr2_first", out_ch, 0);
    tick();
    check("rr2_second", out_ch, 2);
    tick();
    check("rr2_idle", out_valid, 0);
    bus_enable = '0;
    repeat (4) tick();

    // Backpressure
    out_ready = 1'b0;
    sb.push_back({2'd1, 8'hC5});
    set_ch(1, 8'hC5, 1'b1);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 8'hC5);
      check("bp_ch", out_ch, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_drain", out_valid, 0);
    bus_enable = '0;
    repeat (4) tick();

    // Overflow: output occupied by ch1, ch2 slot full, second ch2 word dropped
    out_ready = 1'b0;
    sb.push_back({2'd1, 8'h99});
    sb.push_back({2'd2, 8'h3C});
    set_ch(1, 8'h99, 1'b1);
    repeat (4) tick();
    set_ch(2, 8'h3C, 1'b1);
    repeat (4) tick();
    check("ovf_before", overflow, 0);
    set_ch(2, 8'h00, 1'b0);
    repeat (4) tick();
    set_ch(2, 8'h5A, 1'b1);
    tick(); tick();
    check("ovf_e2", overflow, 0);
    tick();
    check("ovf_set", overflow, 4'b0100);
    check("ovf_pulse", enable_pulse, 4'b0100);
    tick();
    check("ovf_sticky", overflow, 4'b0100);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    out_ready = 1'b1;
    tick();
    check("ovf_deliver_valid", out_valid, 1);
    check("ovf_deliver_data", out_data, 8'h3C);
    tick();
    check("ovf_idle", out_valid, 0);
    bus_enable = '0;
    repeat (4) tick();

    // Async reset while output and a holding slot are occupied
    out_ready = 1'b0;
    set_ch(0, 8'h11, 1'b1);
    set_ch(3, 8'h33, 1'b1);
    repeat (4) tick();
    check("mr_valid", out_valid, 1);
    check("mr_ch", out_ch, 3);
    #2;
    RST = 1'b1;
    #1;
    check("mr_valid_rst", out_valid, 0);
    check("mr_data_rst", out_data, 0);
    check("mr_ch_rst", out_ch, 0);
    check("mr_pulse_rst", enable_pulse, 0);
    bus_enable = '0;
    tick(); tick();
    RST = 1'b0;
    out_ready = 1'b1;
    sb.push_back({2'd0, 8'h44});
    sb.push_back({2'd1, 8'h55});
    set_ch(1, 8'h55, 1'b1);
    set_ch(0, 8'h44, 1'b1);
    repeat (4) tick();
    check("mr_first", out_ch, 0);
    tick();
    check("mr_second", out_ch, 1);
    tick();
    check("mr_idle", out_valid, 0);
    bus_enable = '0;
    repeat (4) tick();

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
